// File: rtl/blocks_pkt_buf_pkg.sv
// Shared types for the block-granular pixel buffer: beat/marker layout and write FSM states.
package blocks_pkt_buf_pkg;

    localparam int N_DEF  = 2;
    localparam int CH_DEF = 3;
    localparam int DW_DEF = 8;

    function automatic int bb_beats(input int n);
        return 64 / n;
    endfunction

    typedef struct packed {
        logic sof;
        logic sob;
        logic eob;
    } marker_t;

    typedef logic [CH_DEF-1:0][N_DEF-1:0][DW_DEF-1:0] beat_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

endpackage

// File: rtl/blocks_pkt_buf_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module bb_sdp_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/blocks_pkt_buf.sv
// Elastic buffer of whole 8x8 blocks; only complete, well-formed blocks reach the output.
//  state   | meaning
//  WR_IDLE | waiting for a start-of-block beat
//  WR_FILL | block admitted, beats being written at wr_ptr
//  WR_DROP | block refused or broken, discarding until eob/sob
module blocks_pkt_buf
    import blocks_pkt_buf_pkg::*;
#(
    parameter int N         = 2,
    parameter int CH        = 3,
    parameter int DW        = 8,
    parameter int DEPTH_BLK = 4,
    parameter int AF_BLK    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_err,
    input  logic                           in_valid,
    input  logic [CH-1:0][N-1:0][DW-1:0]   in_data,
    input  logic                           in_sob,
    input  logic                           in_eob,
    input  logic                           in_sof,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH-1:0][N-1:0][DW-1:0]   out_data,
    output logic                           out_sob,
    output logic                           out_eob,
    output logic                           out_sof,
    output logic [$clog2(DEPTH_BLK):0]     level_blk,
    output logic                           almost_full,
    output logic                           overflow,
    output logic                           proto_err,
    output logic [15:0]                    drop_cnt
);
    localparam int BB    = bb_beats(N);
    localparam int DEPTH = DEPTH_BLK * BB;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(BB);
    localparam int DATW  = CH * N * DW;
    localparam int RW    = DATW + 3;
    localparam int LW    = $clog2(DEPTH_BLK) + 1;
    localparam logic [AW:0]   P_ONE  = 1;
    localparam logic [BW-1:0] BI_ONE = 1;

    wr_state_e     state;
    logic [AW:0]   wr_ptr, wr_commit, rd_addr, commit_eff;
    logic [BW-1:0] bi;
    logic [LW-1:0] occ_blk;
    logic          in_fill, last, sob_in, space, admit, refuse, admit_bad;
    logic          abort_fill, commit, stray, proto_set;
    logic [1:0]    drop_n;
    logic [16:0]   drop_sum;

    always_comb begin
        in_fill    = (state == WR_FILL);
        last       = (bi == BW'(BB - 1));
        sob_in     = in_valid && in_sob;
        space      = (occ_blk < LW'(DEPTH_BLK));
        admit      = sob_in && space;
        refuse     = sob_in && !space;
        admit_bad  = admit && in_eob;
        abort_fill = in_valid && in_fill && (in_sob || (in_eob != last));
        commit     = in_valid && in_fill && !in_sob && in_eob && last;
        stray      = in_valid && !in_sob && (state == WR_IDLE);
        proto_set  = abort_fill || admit_bad || stray;
        drop_n     = 2'(abort_fill) + 2'(refuse) + 2'(admit_bad);
    end

    // A new sob always restarts from the commit point, abandoning any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WR_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            bi        <= '0;
        end else if (sob_in) begin
            wr_ptr <= (admit && !in_eob) ? wr_commit + P_ONE : wr_commit;
            bi     <= (admit && !in_eob) ? BI_ONE : '0;
            if (admit && !in_eob)       state <= WR_FILL;
            else if (refuse && !in_eob) state <= WR_DROP;
            else                        state <= WR_IDLE;
        end else if (in_valid) begin
            case (state)
                WR_FILL: begin
                    if (commit) begin
                        wr_ptr    <= wr_ptr + P_ONE;
                        wr_commit <= wr_ptr + P_ONE;
                        bi        <= '0;
                        state     <= WR_IDLE;
                    end else if (abort_fill) begin
                        wr_ptr <= wr_commit;
                        bi     <= '0;
                        state  <= in_eob ? WR_IDLE : WR_DROP;
                    end else begin
                        wr_ptr <= wr_ptr + P_ONE;
                        bi     <= bi + BI_ONE;
                    end
                end
                WR_DROP: if (in_eob) state <= WR_IDLE;
                default: ;
            endcase
        end
    end

    logic [RW-1:0] wdata, rdata, e0, e1;
    logic [1:0]    cnt;
    logic          fetch_pend, issue, pop, pop_eob;
    marker_t       mk;

    assign wdata = {marker_t'{sof: in_sof, sob: in_sob, eob: in_eob}, in_data};

    bb_sdp_ram #(.W(RW), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    ((in_valid && in_fill) || admit),
        .waddr (in_sob ? wr_commit[AW-1:0] : wr_ptr[AW-1:0]),
        .wdata (wdata),
        .re    (issue),
        .raddr (rd_addr[AW-1:0]),
        .rdata (rdata)
    );

    // Look ahead to the commit in progress so the first beat appears two cycles after eob.
    assign commit_eff = commit ? wr_ptr + P_ONE : wr_commit;
    assign out_valid  = (cnt != 2'd0);
    assign pop        = out_valid && out_ready;
    assign issue      = (rd_addr != commit_eff) &&
                        (({1'b0, cnt} + 3'(fetch_pend) - 3'(pop)) <= 3'd1);
    assign mk         = marker_t'(e0[RW-1:DATW]);
    assign out_data   = e0[DATW-1:0];
    assign out_sof    = mk.sof;
    assign out_sob    = mk.sob;
    assign out_eob    = mk.eob;
    assign pop_eob    = pop && mk.eob;
    assign level_blk  = occ_blk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fetch_pend <= 1'b0;
            rd_addr    <= '0;
            e0         <= '0;
            e1         <= '0;
        end else begin
            fetch_pend <= issue;
            if (issue) rd_addr <= rd_addr + P_ONE;
            case ({fetch_pend, pop})
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= rdata;
                    end else begin
                        e0 <= rdata;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) e0 <= rdata;
                    else             e1 <= rdata;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign drop_sum = (clr_err ? 17'd0 : {1'b0, drop_cnt}) + 17'(drop_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_blk     <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            occ_blk     <= occ_blk + LW'(commit) - LW'(pop_eob);
            almost_full <= ((DEPTH_BLK - int'(occ_blk) - int'(in_fill)) <= AF_BLK);
            overflow    <= refuse || (overflow && !clr_err);
            proto_err   <= proto_set || (proto_err && !clr_err);
            drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: tb/tb_blocks_pkt_buf.sv
// Directed bench for blocks_pkt_buf: ordering, admission, malformed blocks, stalls, reset.
module tb_blocks_pkt_buf;
    import blocks_pkt_buf_pkg::*;

    localparam int N = 2, CH = 3, DW = 8, DEPTH_BLK = 4, AF_BLK = 1, BB = 64 / N;

    typedef struct packed {
        logic  sof;
        logic  sob;
        logic  eob;
        beat_t data;
    } rec_t;

    logic        clk = 1'b0, rst_n = 1'b0, clr_err = 1'b0, out_ready = 1'b0;
    logic        in_valid = 1'b0, in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
    beat_t       in_data = '0;
    beat_t       out_data;
    logic        out_valid, out_sob, out_eob, out_sof, almost_full, overflow, proto_err;
    logic [2:0]  level_blk;
    logic [15:0] drop_cnt;

    int   checks = 0, failures = 0, cyc = 0, first_vcyc = -1, stall_err = 0, eob_cyc = 0;
    bit   rnd_ready = 1'b0, stall_prev = 1'b0;
    rec_t stall_val, cur;
    rec_t got_q[$], exp_q[$];

    blocks_pkt_buf #(.N(N), .CH(CH), .DW(DW), .DEPTH_BLK(DEPTH_BLK), .AF_BLK(AF_BLK)) dut (
        .clk(clk), .rst_n(rst_n), .clr_err(clr_err),
        .in_valid(in_valid), .in_data(in_data), .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
        .level_blk(level_blk), .almost_full(almost_full), .overflow(overflow),
        .proto_err(proto_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output monitor: captures handshakes and flags any change of out_* while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            cur = '{sof: out_sof, sob: out_sob, eob: out_eob, data: out_data};
            if (stall_prev && (cur !== stall_val || out_valid !== 1'b1)) stall_err++;
            if (out_valid && first_vcyc < 0) first_vcyc = cyc;
            if (out_valid && out_ready) got_q.push_back(cur);
            stall_prev = out_valid && !out_ready;
            stall_val  = cur;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench timeout");
    end

    function automatic beat_t mk_data(input int blk, input int k);
        beat_t d;
        for (int p = 0; p < N; p++) begin
            d[0][p] = 8'(8'hA0 + 2 * k + p);
            d[1][p] = 8'(blk * 8 + p);
            d[2][p] = 8'(k * 5 + blk);
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send(input int blk, input bit sof, input int nbeats, input int eob_at);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_sob   = (k == 0);
            in_eob   = (k == eob_at);
            in_sof   = sof && (k == 0);
            in_data  = mk_data(blk, k);
            if (k == eob_at) eob_cyc = cyc;
            tick();
        end
    endtask

    task automatic add_exp(input int blk, input bit sof);
        rec_t r;
        for (int k = 0; k < BB; k++) begin
            r = '{sof: sof && (k == 0), sob: (k == 0), eob: (k == BB - 1), data: mk_data(blk, k)};
            exp_q.push_back(r);
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_no_timeout"}, 64'(n < 2000), 64'd1);
        repeat (20) tick();
        chk({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            int f0 = failures;
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            if (failures != f0) break;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level_blk, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // four back-to-back blocks, sink always ready
        out_ready  = 1'b1;
        first_vcyc = -1;
        send(0, 1'b1, BB, BB - 1);
        add_exp(0, 1'b1);
        for (int b = 1; b < 4; b++) begin
            send(b, 1'b0, BB, BB - 1);
            add_exp(b, 1'b0);
        end
        idle();
        drain("b2b");
        chk("b2b_latency", 64'(first_vcyc - (eob_cyc - 3 * BB)), 64'd2);
        chk("b2b_level", level_blk, 0);
        chk("b2b_perr", proto_err, 0);

        // stalled sink: five blocks, fifth refused
        out_ready = 1'b0;
        send(10, 1'b1, BB, BB - 1);
        send(11, 1'b0, BB, BB - 1);
        idle();
        repeat (3) tick();
        chk("ovf_af_after2", almost_full, 0);
        chk("ovf_level2", level_blk, 2);
        send(12, 1'b0, BB, BB - 1);
        idle();
        repeat (3) tick();
        chk("ovf_af_after3", almost_full, 1);
        chk("ovf_level3", level_blk, 3);
        send(13, 1'b0, BB, BB - 1);
        send(14, 1'b0, BB, BB - 1);
        idle();
        repeat (3) tick();
        chk("ovf_level4", level_blk, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_perr", proto_err, 0);
        for (int b = 10; b < 14; b++) add_exp(b, b == 10);
        out_ready = 1'b1;
        drain("ovf");
        chk("ovf_level_end", level_blk, 0);
        pulse_clr();
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);

        // early eob: block discarded, next one unaffected
        send(20, 1'b0, 21, 20);
        idle();
        repeat (2) tick();
        chk("early_perr", proto_err, 1);
        chk("early_drop", drop_cnt, 1);
        chk("early_level", level_blk, 0);
        chk("early_ovf", overflow, 0);
        send(21, 1'b0, BB, BB - 1);
        add_exp(21, 1'b0);
        idle();
        drain("early");
        pulse_clr();
        chk("clr_perr", proto_err, 0);

        // sob at beat 10 of an open block
        send(30, 1'b0, 10, -1);
        send(31, 1'b1, BB, BB - 1);
        add_exp(31, 1'b1);
        idle();
        drain("resob");
        chk("resob_perr", proto_err, 1);
        chk("resob_drop", drop_cnt, 1);
        pulse_clr();

        // random sink stalls
        rnd_ready = 1'b1;
        for (int b = 40; b < 43; b++) begin
            send(b, b == 40, BB, BB - 1);
            add_exp(b, b == 40);
        end
        idle();
        drain("rnd");
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        chk("rnd_stall_stable", 64'(stall_err), 64'd0);
        chk("rnd_drop", drop_cnt, 0);

        // async reset mid-block with two blocks stored
        out_ready = 1'b0;
        send(50, 1'b1, BB, BB - 1);
        send(51, 1'b0, BB, BB - 1);
        send(52, 1'b0, 10, -1);
        idle();
        tick();
        chk("ar_pre_level", level_blk, 2);
        chk("ar_pre_valid", out_valid, 1);
        chk("ar_pre_data", 64'(out_data), 64'(mk_data(50, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", 64'(out_data), 64'd0);
        chk("ar_sob", out_sob, 0);
        chk("ar_level", level_blk, 0);
        chk("ar_af", almost_full, 0);
        repeat (2) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(60, 1'b1, BB, BB - 1);
        add_exp(60, 1'b1);
        idle();
        drain("ar_after");
        chk("ar_after_level", level_blk, 0);
        chk("ar_after_drop", drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
